gain_pipe_top: RTL and testbench

GAIN_PIPE_TOP -- requirements
Module: gain_pipe_top

---
 rtl/gain_pipe_top.sv | 267 ++++++++++++++++++++++++++
 tb/tb_gain_pipe_top.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_pipe_top.sv
`default_nettype none
// ============================================================================
// Module   : gain_pipe_top
// Purpose  : Streaming fixed-point gain stage. Samples are pushed into an
//            input FIFO, multiplied by a signed Q-format gain in a three-stage
//            pipeline, and collected in an output FIFO.
//            dout = sat((din * gain) >>> FRAC_BITS).
//            The input FIFO is popped only when the output FIFO is guaranteed
//            to have room for every sample already in the pipeline, so an
//            arbitrarily long output stall never loses data.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   GAIN_PIPE_SAT_EN  defined   : out-of-range results clamp to max/min.
//                     undefined : results wrap to the low DATA_WIDTH bits.
//   Either way sat_flag records that a result did not fit.
// ----------------------------------------------------------------------------
// Ports:
//   clock       in   1           sole clock, rising edge
//   reset       in   1           synchronous, active-low
//   din         in   DATA_WIDTH  input sample (signed)
//   in_wr_en    in   1           push din into the input FIFO
//   in_full     out  1           input FIFO full
//   dout        out  DATA_WIDTH  head of the output FIFO (0 when empty)
//   out_rd_en   in   1           pop the output FIFO
//   out_empty   out  1           output FIFO empty
//   gain_in     in   GAIN_WIDTH  new gain value (signed, Q FRAC_BITS)
//   gain_wr_en  in   1           load gain_in on the next edge
//   gain        out  GAIN_WIDTH  current gain register
//   sat_flag    out  1           sticky out-of-range indicator
//   sat_clr     in   1           clear sat_flag (a new set wins)
// ============================================================================
module gain_pipe_top #(
   parameter int DATA_WIDTH = 32,
   parameter int GAIN_WIDTH = 16,
   parameter int FRAC_BITS  = 10,
   parameter int FIFO_DEPTH = 16,
   parameter int GAIN_INIT  = 1 << FRAC_BITS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  in_wr_en,
   output logic                  in_full,
   output logic [DATA_WIDTH-1:0] dout,
   input  logic                  out_rd_en,
   output logic                  out_empty,
   input  logic [GAIN_WIDTH-1:0] gain_in,
   input  logic                  gain_wr_en,
   output logic [GAIN_WIDTH-1:0] gain,
   output logic                  sat_flag,
   input  logic                  sat_clr
);

   // -------------------------------------------------------------------------
   // Derived sizes and constants
   // -------------------------------------------------------------------------
   localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH;
   localparam int PTR_WIDTH  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
   // out_count + inflight can reach FIFO_DEPTH + 3
   localparam int SUM_WIDTH  = CNT_WIDTH + 2;

   localparam logic [PTR_WIDTH-1:0]  PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
   localparam logic [PTR_WIDTH-1:0]  PTR_ONE  = PTR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [SUM_WIDTH-1:0]  SUM_CAP  = SUM_WIDTH'(FIFO_DEPTH);
   localparam logic [GAIN_WIDTH-1:0] GAIN_RST = GAIN_WIDTH'(GAIN_INIT);

   localparam logic [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // -------------------------------------------------------------------------
   // Input FIFO
   // -------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] in_mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  in_wr_ptr;
   logic [PTR_WIDTH-1:0]  in_rd_ptr;
   logic [CNT_WIDTH-1:0]  in_count;
   logic                  in_empty;
   logic                  in_push;
   logic                  in_pop;

   assign in_full  = (in_count == CNT_FULL);
   assign in_empty = (in_count == '0);
   assign in_push  = in_wr_en & ~in_full;

   always_ff @(posedge clock) begin
      if (!reset) begin
         in_wr_ptr <= '0;
         in_rd_ptr <= '0;
         in_count  <= '0;
      end else begin
         if (in_push) begin
            in_wr_ptr <= (in_wr_ptr == PTR_LAST) ? '0 : in_wr_ptr + PTR_ONE;
         end
         if (in_pop) begin
            in_rd_ptr <= (in_rd_ptr == PTR_LAST) ? '0 : in_rd_ptr + PTR_ONE;
         end
         case ({in_push, in_pop})
            2'b10:   in_count <= in_count + CNT_ONE;
            2'b01:   in_count <= in_count - CNT_ONE;
            default: in_count <= in_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset && in_push) begin
         in_mem[in_wr_ptr] <= din;
      end
   end

   // -------------------------------------------------------------------------
   // Pipeline control
   // Stage 1: sample + gain captured at pop
   // Stage 2: full-precision product
   // Stage 3: shifted, range-checked result; written to the output FIFO
   // -------------------------------------------------------------------------
   logic                  s1_valid;
   logic                  s2_valid;
   logic                  s3_valid;
   logic [1:0]            inflight;
   logic [CNT_WIDTH-1:0]  out_count;
   logic [SUM_WIDTH-1:0]  committed;
   logic                  room;

   assign inflight  = 2'(s1_valid) + 2'(s2_valid) + 2'(s3_valid);
   // Reserve an output slot for every sample already in flight before
   // popping another one; this is what makes the output FIFO unable to
   // overflow regardless of how long out_rd_en stays low.
   assign committed = SUM_WIDTH'(out_count) + SUM_WIDTH'(inflight);
   assign room      = (committed < SUM_CAP);
   assign in_pop    = ~in_empty & room;

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
      end else begin
         s1_valid <= in_pop;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
      end
   end

   // -------------------------------------------------------------------------
   // Datapath
   // -------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0]        s1_data;
   logic [GAIN_WIDTH-1:0]        s1_gain;
   logic signed [PROD_WIDTH-1:0] s1_data_ext;
   logic signed [PROD_WIDTH-1:0] s1_gain_ext;
   logic signed [PROD_WIDTH-1:0] prod;
   logic signed [PROD_WIDTH-1:0] s2_prod;
   logic signed [PROD_WIDTH-1:0] shifted;
   logic [PROD_WIDTH-DATA_WIDTH:0] upper;
   logic                         ovf;
   logic [DATA_WIDTH-1:0]        result;
   logic [DATA_WIDTH-1:0]        s3_data;
   logic                         s3_ovf;

   // Both operands are sign-extended to the full product width so the
   // multiply is exact and signed.
   assign s1_data_ext = {{GAIN_WIDTH{s1_data[DATA_WIDTH-1]}}, s1_data};
   assign s1_gain_ext = {{DATA_WIDTH{s1_gain[GAIN_WIDTH-1]}}, s1_gain};
   assign prod        = s1_data_ext * s1_gain_ext;

   assign shifted = s2_prod >>> FRAC_BITS;

   // The result fits in DATA_WIDTH bits exactly when every bit from the
   // output sign bit upward is identical.
   assign upper = shifted[PROD_WIDTH-1:DATA_WIDTH-1];
   assign ovf   = ~((&upper) | ~(|upper));

`ifdef GAIN_PIPE_SAT_EN
   assign result = ovf ? (shifted[PROD_WIDTH-1] ? DATA_MIN : DATA_MAX)
                       : shifted[DATA_WIDTH-1:0];
`else
   assign result = shifted[DATA_WIDTH-1:0];
`endif

   // Data registers carry no reset; the valid bits qualify them.
   always_ff @(posedge clock) begin
      if (in_pop) begin
         s1_data <= in_mem[in_rd_ptr];
         s1_gain <= gain;
      end
      if (s1_valid) begin
         s2_prod <= prod;
      end
      if (s2_valid) begin
         s3_data <= result;
         s3_ovf  <= ovf;
      end
   end

   // -------------------------------------------------------------------------
   // Gain register
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         gain <= GAIN_RST;
      end else if (gain_wr_en) begin
         gain <= gain_in;
      end
   end

   // -------------------------------------------------------------------------
   // Sticky saturation flag: set when an out-of-range result is written
   // to the output FIFO; a set in the same cycle overrides sat_clr.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         sat_flag <= 1'b0;
      end else if (s3_valid && s3_ovf) begin
         sat_flag <= 1'b1;
      end else if (sat_clr) begin
         sat_flag <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Output FIFO
   // -------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] out_mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  out_wr_ptr;
   logic [PTR_WIDTH-1:0]  out_rd_ptr;
   logic                  out_push;
   logic                  out_pop;

   assign out_push  = s3_valid;
   assign out_empty = (out_count == '0);
   assign out_pop   = out_rd_en & ~out_empty;
   // Memory contents survive reset, so the head is masked while empty.
   assign dout      = out_empty ? '0 : out_mem[out_rd_ptr];

   always_ff @(posedge clock) begin
      if (!reset) begin
         out_wr_ptr <= '0;
         out_rd_ptr <= '0;
         out_count  <= '0;
      end else begin
         if (out_push) begin
            out_wr_ptr <= (out_wr_ptr == PTR_LAST) ? '0 : out_wr_ptr + PTR_ONE;
         end
         if (out_pop) begin
            out_rd_ptr <= (out_rd_ptr == PTR_LAST) ? '0 : out_rd_ptr + PTR_ONE;
         end
         case ({out_push, out_pop})
            2'b10:   out_count <= out_count + CNT_ONE;
            2'b01:   out_count <= out_count - CNT_ONE;
            default: out_count <= out_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset && out_push) begin
         out_mem[out_wr_ptr] <= s3_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gain_pipe_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_gain_pipe_top
// Purpose  : Self-checking bench for gain_pipe_top. A driver pushes samples
//            and records the expected output in a queue; an independent
//            monitor pops the queue whenever the DUT output is read.
//            Honours GAIN_PIPE_SAT_EN in its reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gain_pipe_top;

   localparam int DW    = 32;
   localparam int GW    = 16;
   localparam int FB    = 10;
   localparam int DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] din = '0;
   logic          in_wr_en = 1'b0;
   logic          in_full;
   logic [DW-1:0] dout;
   logic          out_rd_en = 1'b0;
   logic          out_empty;
   logic [GW-1:0] gain_in = '0;
   logic          gain_wr_en = 1'b0;
   logic [GW-1:0] gain;
   logic          sat_flag;
   logic          sat_clr = 1'b0;

   gain_pipe_top #(
      .DATA_WIDTH(DW), .GAIN_WIDTH(GW), .FRAC_BITS(FB),
      .FIFO_DEPTH(DEPTH), .GAIN_INIT(1 << FB)
   ) dut (
      .clock(clock), .reset(reset), .din(din), .in_wr_en(in_wr_en),
      .in_full(in_full), .dout(dout), .out_rd_en(out_rd_en),
      .out_empty(out_empty), .gain_in(gain_in), .gain_wr_en(gain_wr_en),
      .gain(gain), .sat_flag(sat_flag), .sat_clr(sat_clr)
   );

   always #5 clock = ~clock;

   int                   n_cmp = 0;
   int                   n_err = 0;
   int                   cyc = 0;
   int                   rd_mode = 0;       // 0 hold low, 1 always, 2 random
   logic [DW-1:0]        exp_q[$];
   logic signed [GW-1:0] model_gain = 16'sh0400;
   bit                   exp_sat = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (plain integer arithmetic) ------------
   function automatic longint model_q(input logic [DW-1:0] d, input logic signed [GW-1:0] g);
      longint p;
      p = longint'($signed(d)) * longint'(g);
      return p >>> FB;
   endfunction

   function automatic bit model_ovf(input longint q);
      return (q > 64'sd2147483647) || (q < -64'sd2147483648);
   endfunction

   function automatic logic [DW-1:0] model_out(input longint q);
      logic [DW-1:0] r;
      r = q[DW-1:0];
`ifdef GAIN_PIPE_SAT_EN
      if (q > 64'sd2147483647)  r = 32'h7FFF_FFFF;
      if (q < -64'sd2147483648) r = 32'h8000_0000;
`endif
      return r;
   endfunction

   // ---------------- output reader and monitor -----------------------------
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (rd_mode)
            0:       out_rd_en = 1'b0;
            1:       out_rd_en = 1'b1;
            default: out_rd_en = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clock) begin : monitor
      logic [DW-1:0] e;
      if (reset && out_rd_en && !out_empty) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(dout), 64'hDEAD_0000_0000_0000);
         end else begin
            e = exp_q.pop_front();
            check("dout", 64'(dout), 64'(e));
         end
      end
   end

   // ---------------- driver tasks ------------------------------------------
   task automatic push(input logic [DW-1:0] d, output bit acc);
      longint q;
      @(posedge clock);
      #1;
      din      = d;
      in_wr_en = 1'b1;
      @(negedge clock);
      acc = !in_full;
      if (acc) begin
         q = model_q(d, model_gain);
         exp_q.push_back(model_out(q));
         if (model_ovf(q)) exp_sat = 1'b1;
      end
   endtask

   task automatic idle_in();
      @(posedge clock);
      #1;
      in_wr_en = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      rd_mode = 1;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clock);
         n++;
      end
      check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
      repeat (6) @(negedge clock);
      check({name, "_empty_after"}, 64'(out_empty), 64'd1);
   endtask

   task automatic set_gain(input logic [GW-1:0] g);
      @(posedge clock);
      #1;
      gain_in    = g;
      gain_wr_en = 1'b1;
      @(posedge clock);
      #1;
      gain_wr_en = 1'b0;
      model_gain = g;
      @(negedge clock);
      check("gain_readback", 64'(gain), 64'(g));
   endtask

   task automatic clear_sat();
      @(posedge clock);
      #1;
      sat_clr = 1'b1;
      @(posedge clock);
      #1;
      sat_clr = 1'b0;
      exp_sat = 1'b0;
      @(negedge clock);
      check("sat_clr", 64'(sat_flag), 64'd0);
   endtask

   // ---------------- watchdog ----------------------------------------------
   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence -----------------------------------------
   initial begin : main
      bit acc;
      int n_acc;
      int fall;
      int t0;
      int n;
      int bad;
      logic [DW-1:0] d;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_out_empty", 64'(out_empty), 64'd1);
      check("rst_in_full",   64'(in_full),   64'd0);
      check("rst_dout",      64'(dout),      64'd0);
      check("rst_gain",      64'(gain),      64'h0400);
      check("rst_sat_flag",  64'(sat_flag),  64'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Unity gain
      rd_mode = 1;
      push(32'd100, acc);
      push(-32'sd7, acc);
      push(32'd0, acc);
      idle_in();
      drain("unity");
      check("unity_sat", 64'(sat_flag), 64'd0);

      // Gain 0.5 with arithmetic floor
      set_gain(16'h0200);
      push(32'd1000, acc);
      push(-32'sd1001, acc);
      idle_in();
      drain("half");

      // Gain written in the same cycle the sample is popped: old gain applies
      push(32'd1000, acc);
      @(posedge clock);
      #1;
      in_wr_en   = 1'b0;
      gain_in    = 16'h0400;
      gain_wr_en = 1'b1;
      @(posedge clock);
      #1;
      gain_wr_en = 1'b0;
      model_gain = 16'sh0400;
      push(32'd1000, acc);
      idle_in();
      drain("gain_edge");

      // Backpressure: 40 pushes, no reads
      rd_mode = 0;
      repeat (3) @(posedge clock);
      n_acc = 0;
      fall  = -1;
      for (int i = 0; i < 40; i++) begin
         push(32'(i * 3 - 50), acc);
         if (acc) n_acc++;
         if (!out_empty && fall < 0) fall = i;
      end
      idle_in();
      check("bp_accepted", 64'(n_acc), 64'd32);
      check("bp_in_full", 64'(in_full), 64'd1);
      check("bp_empty_fall", 64'((fall >= 0) && (fall <= 6)), 64'd1);
      drain("bp");

      // Throughput: back-to-back samples with the output drained every cycle
      rd_mode = 1;
      for (int i = 0; i < 20; i++) push(32'(i * 11), acc);
      idle_in();
      t0 = cyc;
      n  = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("throughput", 64'((cyc - t0) <= 8), 64'd1);
      drain("tp");

      // Saturation / wrap
      set_gain(16'h7FFF);
      push(32'h7FFF_FFFF, acc);
      idle_in();
      drain("sat");
      check("sat_flag_set", 64'(sat_flag), 64'd1);
      clear_sat();

      // Randomized phases
      for (int p = 0; p < 6; p++) begin
         set_gain(16'($urandom));
         rd_mode = 2;
         for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) d = 32'($urandom);
            else d = 32'($urandom_range(0, 4000)) - 32'd2000;
            push(d, acc);
            if ($urandom_range(0, 2) == 0) begin
               idle_in();
               repeat ($urandom_range(0, 2)) @(posedge clock);
            end
         end
         idle_in();
         drain("rand");
         check("rand_sat_flag", 64'(sat_flag), 64'(exp_sat));
         if (exp_sat) clear_sat();
      end

      // Reset mid-stream with three samples in the pipeline
      set_gain(16'h0123);
      rd_mode = 0;
      push(32'd5, acc);
      push(32'd6, acc);
      push(32'd7, acc);
      idle_in();
      @(posedge clock);
      #1;
      reset      = 1'b0;
      rd_mode    = 1;
      in_wr_en   = 1'b1;
      din        = 32'd99;
      gain_in    = 16'h5555;
      gain_wr_en = 1'b1;
      sat_clr    = 1'b1;
      @(posedge clock);
      @(negedge clock);
      exp_q.delete();
      check("mid_rst_out_empty", 64'(out_empty), 64'd1);
      check("mid_rst_in_full",   64'(in_full),   64'd0);
      check("mid_rst_dout",      64'(dout),      64'd0);
      check("mid_rst_gain",      64'(gain),      64'h0400);
      check("mid_rst_sat",       64'(sat_flag),  64'd0);
      @(posedge clock);
      #1;
      reset      = 1'b1;
      in_wr_en   = 1'b0;
      gain_wr_en = 1'b0;
      sat_clr    = 1'b0;
      model_gain = 16'sh0400;
      exp_sat    = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clock);
         if (!out_empty) bad++;
      end
      check("post_rst_no_output", 64'(bad), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
